// File: rtl/commutation_scheduler.sv
// Commutation scheduler: steps a 3-phase rotation table through a load/ack handshake with per-step dwell and sticky faults.
// Optional ack watchdog is compiled in with SCHED_WATCHDOG_EN.
module commutation_scheduler #(
  parameter int DWELL_W    = 16,
  parameter int WDOG_LIMIT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               dir,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               comm_ack,
  input  logic               short_in,
  input  logic               fault_clr,
  output logic [5:0]         desired_load,
  output logic               load_req,
  output logic               start_out,
  output logic [1:0]         step_idx,
  output logic               fault,
  output logic [1:0]         fault_code
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_ACK, S_DWELL, S_PARK, S_FAULT
  } state_t;

  localparam logic [1:0] PH_A = 2'b01;
  localparam logic [1:0] PH_B = 2'b10;
  localparam logic [1:0] PH_C = 2'b11;
  localparam logic [DWELL_W-1:0] CNT_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

  if (WDOG_LIMIT < 1) begin : g_wdog_limit_invalid
    $error("WDOG_LIMIT must be at least 1");
  end

  function automatic logic [5:0] rot_load(input logic [1:0] step);
    case (step)
      2'd1:    rot_load = {PH_B, PH_C, PH_A};
      2'd2:    rot_load = {PH_C, PH_A, PH_B};
      default: rot_load = {PH_A, PH_B, PH_C};
    endcase
  endfunction

  state_t             state_q, state_d;
  logic [1:0]         step_q, step_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [5:0]         desired_q, desired_d;
  logic               load_req_q, load_req_d;
  logic               start_q, start_d;
  logic               fault_q, fault_d;
  logic [1:0]         fault_code_q, fault_code_d;
  logic               wdog_timeout;

`ifdef SCHED_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_LIMIT + 1);
  logic [WDOG_W-1:0] wdog_q, wdog_d;
`endif

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    cnt_d        = cnt_q;
    fault_code_d = fault_code_q;
    wdog_timeout = 1'b0;

`ifdef SCHED_WATCHDOG_EN
    wdog_d = '0;
    if ((state_q == S_WAIT_ACK || state_q == S_PARK) && !comm_ack) begin
      if (wdog_q == WDOG_W'(WDOG_LIMIT - 1)) wdog_timeout = 1'b1;
      else                                   wdog_d = wdog_q + 1'b1;
    end
`endif

    case (state_q)
      S_IDLE:  if (enable) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (comm_ack) begin
          state_d = S_DWELL;
          cnt_d   = (dwell == '0) ? CNT_ONE : dwell;
        end
      end
      S_DWELL: begin
        if (cnt_q <= CNT_ONE) begin
          if (dir) step_d = (step_q == 2'd0) ? 2'd2 : step_q - 2'd1;
          else     step_d = (step_q == 2'd2) ? 2'd0 : step_q + 2'd1;
          state_d = enable ? S_ISSUE : S_PARK;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_PARK: if (comm_ack) state_d = S_IDLE;
      S_FAULT: begin
        if (fault_clr && !short_in) begin
          state_d      = S_IDLE;
          step_d       = 2'd0;
          fault_code_d = 2'b00;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (wdog_timeout) begin
      state_d         = S_FAULT;
      fault_code_d[1] = 1'b1;
    end

    // A short outranks ack, dwell expiry and fault clear alike.
    if (short_in && state_q != S_IDLE) begin
      state_d         = S_FAULT;
      step_d          = step_q;
      fault_code_d[0] = 1'b1;
    end

`ifndef SCHED_WATCHDOG_EN
    fault_code_d[1] = 1'b0;
`endif

    desired_d  = 6'b000000;
    load_req_d = 1'b0;
    start_d    = 1'b0;
    fault_d    = 1'b0;
    case (state_d)
      S_ISSUE: begin
        desired_d  = rot_load(step_d);
        load_req_d = 1'b1;
        start_d    = 1'b1;
      end
      S_WAIT_ACK: begin
        desired_d  = desired_q;
        load_req_d = 1'b1;
      end
      S_DWELL: desired_d  = desired_q;
      S_PARK:  load_req_d = 1'b1;
      S_FAULT: fault_d    = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      step_q       <= 2'd0;
      cnt_q        <= '0;
      desired_q    <= 6'b000000;
      load_req_q   <= 1'b0;
      start_q      <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= 2'b00;
`ifdef SCHED_WATCHDOG_EN
      wdog_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      cnt_q        <= cnt_d;
      desired_q    <= desired_d;
      load_req_q   <= load_req_d;
      start_q      <= start_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
`ifdef SCHED_WATCHDOG_EN
      wdog_q       <= wdog_d;
`endif
    end
  end

  assign desired_load = desired_q;
  assign load_req     = load_req_q;
  assign start_out    = start_q;
  assign step_idx     = step_q;
  assign fault        = fault_q;
  assign fault_code   = fault_code_q;

endmodule

// File: doc/commutation_scheduler.md
COMMUTATION_SCHEDULER -- requirements
Module: commutation_scheduler

Interface
REQ-001 Parameter DWELL_W, default 16: width of the dwell-period input and the dwell counter.
REQ-002 Parameter WDOG_LIMIT, default 64: WAIT_ACK cycles allowed before a timeout fault (used only under REQ-030).
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-low reset.
REQ-005 Port enable, input, 1: run request; 1 = sequence loads, 0 = park outputs at NUL.
REQ-006 Port dir, input, 1: rotation direction; 0 = forward, 1 = reverse.
REQ-007 Port dwell, input, DWELL_W: cycles each load is held after acknowledgement; 0 is treated as 1.
REQ-008 Port comm_ack, input, 1: commutation block has finished applying the requested load.
REQ-009 Port short_in, input, 1: short detected by the commutation block.
REQ-010 Port fault_clr, input, 1: fault acknowledge.
REQ-011 Port desired_load, output, 6: phase selection as {outA[5:4], outB[3:2], outC[1:0]}; codes NUL=00, A=01, B=10, C=11.
REQ-012 Port load_req, output, 1: desired_load is valid and awaiting comm_ack.
REQ-013 Port start_out, output, 1: drives the commutation block's start pin.
REQ-014 Port step_idx, output, 2: current rotation step, range 0..2.
REQ-015 Port fault, output, 1: scheduler is in FAULT.
REQ-016 Port fault_code, output, 2: bit0 = short fault, bit1 = timeout fault; sticky until cleared.

Function
REQ-017 Rotation table: step0 = {A,B,C}; step1 = {B,C,A}; step2 = {C,A,B}.
REQ-018 Step advance: dir=0 gives 0->1->2->0; dir=1 gives 0->2->1->0; dir is sampled only at the advance.
REQ-019 States: IDLE, ISSUE, WAIT_ACK, DWELL, PARK, FAULT.
REQ-020 IDLE: desired_load=000000, load_req=0, start_out=0; enable=1 -> ISSUE next cycle.
REQ-021 ISSUE (one cycle): desired_load := table[step_idx], load_req=1, start_out=1; -> WAIT_ACK.
REQ-022 WAIT_ACK: load_req and desired_load held stable; comm_ack=1 -> DWELL; load_req is 0 from the first DWELL cycle.
REQ-023 DWELL: lasts exactly max(dwell,1) cycles, with dwell captured on entry; on the last cycle, advance step_idx and go to ISSUE if enable=1, else PARK.
REQ-024 PARK: desired_load=000000, load_req=1 until comm_ack, then -> IDLE; step_idx is retained.
REQ-025 comm_ack outside WAIT_ACK and PARK is ignored.
REQ-026 short_in=1 in any state except IDLE -> FAULT next cycle; short_in takes priority over a simultaneous comm_ack and over DWELL expiry.
REQ-027 FAULT: desired_load=000000, load_req=0, start_out=0, fault=1, fault_code bit set.
REQ-028 FAULT exit: fault_clr=1 and short_in=0 in the same cycle -> IDLE next cycle, step_idx=0, fault_code=00.
REQ-028a FAULT hold: fault_clr while short_in=1 is ignored.
REQ-029 enable falling during ISSUE or WAIT_ACK does not abort the handshake; it takes effect at DWELL expiry.

Reset
REQ-030a rst=0 at a clock edge -> IDLE, step_idx=0, desired_load=000000, load_req=0, start_out=0, fault=0, fault_code=00, dwell and watchdog counters=0.
REQ-030b Reset overrides every state, including mid-handshake and FAULT.

Configuration
REQ-030 Macro SCHED_WATCHDOG_EN.
REQ-030c With SCHED_WATCHDOG_EN defined: a counter runs in WAIT_ACK and PARK; after WDOG_LIMIT cycles without comm_ack -> FAULT with fault_code[1]=1.
REQ-030d Without SCHED_WATCHDOG_EN: no watchdog counter; WAIT_ACK and PARK wait indefinitely; fault_code[1] is tied to 0.

Verification
REQ-031 Reset, enable=0 for 4 cycles -> desired_load=000000, load_req=0, start_out=0.
REQ-032 enable=1, dir=0, dwell=3, comm_ack one cycle after each load_req -> desired_load sequence 011011, 101101, 110110, 011011; each load held 3 cycles after ack.
REQ-033 dir=1 -> step_idx sequence 0, 2, 1, 0.
REQ-034 short_in=1 in the same cycle as comm_ack during WAIT_ACK -> next cycle: fault=1, fault_code=01, desired_load=000000.
REQ-034a fault_clr=1 with short_in=1 -> FAULT held; fault_clr=1 with short_in=0 -> IDLE, step_idx=0.
REQ-035 enable dropped mid-DWELL -> after expiry, PARK issues 000000 with load_req=1; comm_ack -> IDLE.
REQ-036 With SCHED_WATCHDOG_EN, WDOG_LIMIT=64, comm_ack withheld -> fault_code=10 after 64 WAIT_ACK cycles.
REQ-036a Without SCHED_WATCHDOG_EN, comm_ack withheld -> the scheduler stays in WAIT_ACK for 200 cycles.
